// File: rtl/decode_wide.sv
// rtl/decode_wide.sv - WIDTH-slot instruction decoder with branch-speculation tracking
// Optional build macro DECODE_PERF_EN adds perf_bundles / perf_spec_stall counters.

// Per-slot control decode: {sw,lw,r,branch,jmp,hlt} plus ALU func.
module control_unit (
  input  logic [5:0] opcode,
  input  logic [2:0] funct_lo,
  output logic [5:0] ctrl,
  output logic [2:0] func
);
  // Opcode table; unknown opcodes decode to all-zero controls.
  always_comb begin
    ctrl = 6'b000000;
    func = 3'd0;
    case (opcode)
      6'h00: begin ctrl = 6'b001000; func = funct_lo; end  // R-type
      6'h23: ctrl = 6'b010000;                             // lw
      6'h2B: ctrl = 6'b100000;                             // sw
      6'h04: begin ctrl = 6'b000100; func = 3'd1; end      // beq (subtract compare)
      6'h02: ctrl = 6'b000010;                             // j
      6'h3F: ctrl = 6'b000001;                             // hlt
      default: ;
    endcase
  end
endmodule

module decode_wide #(
  parameter int WIDTH      = 2,
  parameter int SPEC_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH*32-1:0]             in_instr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_slot_valid,
  output logic [WIDTH*5-1:0]              out_rs,
  output logic [WIDTH*5-1:0]              out_rt,
  output logic [WIDTH*5-1:0]              out_rd,
  output logic [WIDTH*16-1:0]             out_imm,
  output logic [WIDTH*6-1:0]              out_ctrl,
  output logic [WIDTH*3-1:0]              out_func,
  output logic [WIDTH-1:0]                out_spec,
  input  logic                            br_resolve,
  input  logic                            br_flush,
  output logic [$clog2(SPEC_DEPTH+1)-1:0] spec_count,
  output logic                            halted
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]                     perf_bundles,
  output logic [31:0]                     perf_spec_stall
`endif
);
  localparam int SCW = $clog2(SPEC_DEPTH + 1);
  localparam logic [4:0] DEPTH5 = 5'(SPEC_DEPTH);

  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       slot_valid_q, slot_valid_d;
  logic [WIDTH*5-1:0]     rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [WIDTH*16-1:0]    imm_q, imm_d;
  logic [WIDTH*6-1:0]     ctrl_q, ctrl_d;
  logic [WIDTH*3-1:0]     func_q, func_d;
  logic [WIDTH-1:0]       spec_q, spec_d;
  logic [SCW-1:0]         spec_count_q, spec_count_d;
  logic                   halted_q, halted_d;

  logic [5:0]             dec_ctrl [WIDTH];
  logic [2:0]             dec_func [WIDTH];
  logic [WIDTH-1:0]       slot_live, slot_spec;
  logic                   bundle_hlt;
  logic [2:0]             nb;
  logic [4:0]             depth_sum;
  logic                   depth_ok, accept;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cu
    control_unit u_cu (
      .opcode   (in_instr[32*g+26 +: 6]),
      .funct_lo (in_instr[32*g +: 3]),
      .ctrl     (dec_ctrl[g]),
      .func     (dec_func[g])
    );
  end

  // Walk slots oldest-first: liveness stops after the first hlt, speculation
  // starts after any older branch, and only live branches are counted.
  always_comb begin
    logic br_seen;
    slot_live  = '0;
    slot_spec  = '0;
    bundle_hlt = 1'b0;
    nb         = 3'd0;
    br_seen    = (spec_count_q != '0);
    for (int i = 0; i < WIDTH; i++) begin
      slot_live[i] = !bundle_hlt;
      slot_spec[i] = br_seen;
      if (dec_ctrl[i][2]) begin
        br_seen = 1'b1;
        if (!bundle_hlt) nb = nb + 3'd1;
      end
      if (dec_ctrl[i][0]) bundle_hlt = 1'b1;
    end
  end

  // Whole-bundle admission: a bundle that would overflow the branch budget waits.
  assign depth_sum = 5'(spec_count_q) + 5'(nb);
  assign depth_ok  = (depth_sum <= DEPTH5);
  assign in_ready  = (!out_valid_q || out_ready) && !halted_q && !br_flush && depth_ok;
  assign accept    = in_valid && in_ready;

  // Next state: flush wins; otherwise load on accept, drain on out_ready.
  always_comb begin
    out_valid_d  = out_valid_q;
    slot_valid_d = slot_valid_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    imm_d        = imm_q;
    ctrl_d       = ctrl_q;
    func_d       = func_q;
    spec_d       = spec_q;
    spec_count_d = spec_count_q;
    halted_d     = halted_q;
    if (br_flush) begin
      out_valid_d  = 1'b0;
      spec_count_d = '0;
      halted_d     = 1'b0;
    end else begin
      if (accept) begin
        out_valid_d  = 1'b1;
        slot_valid_d = slot_live;
        spec_d       = slot_spec;
        halted_d     = bundle_hlt;
        for (int i = 0; i < WIDTH; i++) begin
          rs_d[5*i +: 5]   = in_instr[32*i+21 +: 5];
          rt_d[5*i +: 5]   = in_instr[32*i+16 +: 5];
          rd_d[5*i +: 5]   = in_instr[32*i+11 +: 5];
          imm_d[16*i +: 16] = in_instr[32*i +: 16];
          ctrl_d[6*i +: 6] = dec_ctrl[i];
          func_d[3*i +: 3] = dec_func[i];
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      // Resolve with nothing outstanding is ignored so the count never wraps.
      spec_count_d = SCW'(5'(spec_count_q) + (accept ? 5'(nb) : 5'd0)
                          - ((br_resolve && spec_count_q != '0) ? 5'd1 : 5'd0));
    end
  end

  // State registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      slot_valid_q <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      ctrl_q       <= '0;
      func_q       <= '0;
      spec_q       <= '0;
      spec_count_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      slot_valid_q <= slot_valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      imm_q        <= imm_d;
      ctrl_q       <= ctrl_d;
      func_q       <= func_d;
      spec_q       <= spec_d;
      spec_count_q <= spec_count_d;
      halted_q     <= halted_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_slot_valid = slot_valid_q;
  assign out_rs         = rs_q;
  assign out_rt         = rt_q;
  assign out_rd         = rd_q;
  assign out_imm        = imm_q;
  assign out_ctrl       = ctrl_q;
  assign out_func       = func_q;
  assign out_spec       = spec_q;
  assign spec_count     = spec_count_q;
  assign halted         = halted_q;

`ifdef DECODE_PERF_EN
  logic [31:0] perf_bundles_q, perf_bundles_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        depth_stall;

  assign depth_stall = in_valid && !in_ready && !depth_ok;

  // Saturating event counters.
  always_comb begin
    perf_bundles_d = perf_bundles_q;
    perf_stall_d   = perf_stall_q;
    if (accept && perf_bundles_q != 32'hFFFF_FFFF) perf_bundles_d = perf_bundles_q + 32'd1;
    if (depth_stall && perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bundles_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_bundles_q <= perf_bundles_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_bundles    = perf_bundles_q;
  assign perf_spec_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_decode_wide.sv
// tb/tb_decode_wide.sv - self-checking bench for decode_wide with a behavioural model
module tb_decode_wide;
  localparam int W = 2;
  localparam int D = 4;

  localparam logic [31:0] ADD = 32'h0022_1820;
  localparam logic [31:0] BEQ = 32'h1022_0004;
  localparam logic [31:0] LW  = 32'h8C22_0008;
  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, br_resolve, br_flush, halted;
  logic [W*32-1:0] in_instr;
  logic [W-1:0]    out_slot_valid, out_spec;
  logic [W*5-1:0]  out_rs, out_rt, out_rd;
  logic [W*16-1:0] out_imm;
  logic [W*6-1:0]  out_ctrl;
  logic [W*3-1:0]  out_func;
  logic [$clog2(D+1)-1:0] spec_count;
`ifdef DECODE_PERF_EN
  logic [31:0] perf_bundles, perf_spec_stall;
`endif

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_spec;
  bit m_halted, m_ov;
  logic [W-1:0]    m_sv, m_sp;
  logic [W*5-1:0]  m_rs, m_rt, m_rd;
  logic [W*16-1:0] m_imm;
  logic [W*6-1:0]  m_ctrl;
  logic [W*3-1:0]  m_func;

  decode_wide #(.WIDTH(W), .SPEC_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_slot_valid(out_slot_valid),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_func(out_func), .out_spec(out_spec),
    .br_resolve(br_resolve), .br_flush(br_flush), .spec_count(spec_count), .halted(halted)
`ifdef DECODE_PERF_EN
    , .perf_bundles(perf_bundles), .perf_spec_stall(perf_spec_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_ctrl(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: return 6'b001000;
      6'h23: return 6'b010000;
      6'h2B: return 6'b100000;
      6'h04: return 6'b000100;
      6'h02: return 6'b000010;
      6'h3F: return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [2:0] ref_func(input logic [31:0] ins);
    if (ins[31:26] == 6'h00) return ins[2:0];
    if (ins[31:26] == 6'h04) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [31:0] mk(input int kind);
    logic [31:0] r;
    r = $urandom();
    case (kind)
      0: return {6'h00, r[25:0]};
      1: return {6'h23, r[25:0]};
      2: return {6'h2B, r[25:0]};
      3: return {6'h04, r[25:0]};
      4: return {6'h02, r[25:0]};
      5: return {6'h3F, r[25:0]};
      default: return {6'h0F, r[25:0]};
    endcase
  endfunction

  function automatic int rand_kind();
    int v;
    v = $urandom_range(0, 15);
    if (v < 6) return 0;
    if (v < 8) return 1;
    if (v < 9) return 2;
    if (v < 12) return 3;
    if (v < 13) return 4;
    if (v < 14) return 6;
    return (v == 14) ? 5 : 0;
  endfunction

  // branches that precede (or lack) a halt in the bundle
  function automatic int live_branches(input logic [W*32-1:0] b);
    int n;
    logic [31:0] ins;
    n = 0;
    for (int i = 0; i < W; i++) begin
      ins = b[32*i +: 32];
      if (ins[31:26] == 6'h04) n++;
      if (ins[31:26] == 6'h3F) return n;
    end
    return n;
  endfunction

  function automatic bit m_ready();
    return (!m_ov || out_ready) && !m_halted && !br_flush &&
           (m_spec + live_branches(in_instr) <= D);
  endfunction

  task automatic model_reset();
    m_spec = 0; m_halted = 0; m_ov = 0; m_sv = '0; m_sp = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_imm = '0; m_ctrl = '0; m_func = '0;
  endtask

  task automatic model_clock();
    bit acc, dead, anybr;
    int nb;
    logic [31:0] ins;
    acc = in_valid && m_ready();
    nb  = live_branches(in_instr);
    if (br_flush) begin
      m_spec = 0; m_ov = 0; m_halted = 0;
    end else begin
      if (acc) begin
        m_ov = 1; dead = 0; anybr = 0;
        for (int i = 0; i < W; i++) begin
          ins = in_instr[32*i +: 32];
          m_sv[i] = !dead;
          m_sp[i] = (m_spec != 0) || anybr;
          m_rs[5*i +: 5] = ins[25:21];
          m_rt[5*i +: 5] = ins[20:16];
          m_rd[5*i +: 5] = ins[15:11];
          m_imm[16*i +: 16] = ins[15:0];
          m_ctrl[6*i +: 6] = ref_ctrl(ins);
          m_func[3*i +: 3] = ref_func(ins);
          if (ins[31:26] == 6'h04) anybr = 1;
          if (ins[31:26] == 6'h3F) dead = 1;
        end
        m_halted = dead;
      end else if (out_ready) begin
        m_ov = 0;
      end
      m_spec = m_spec + (acc ? nb : 0) - ((br_resolve && m_spec > 0) ? 1 : 0);
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || halted !== 1'b0 || spec_count !== 3'd0) begin
      errors++; $display("FAIL reset_ctrl got ov=%b h=%b sc=%0d need 0 0 0", out_valid, halted, spec_count); end
    checks++; if ({out_slot_valid, out_spec, out_ctrl, out_func} !== '0) begin
      errors++; $display("FAIL reset_dec got %h need 0", {out_slot_valid, out_spec, out_ctrl, out_func}); end
    checks++; if ({out_rs, out_rt, out_rd, out_imm} !== '0) begin
      errors++; $display("FAIL reset_fields got %h need 0", {out_rs, out_rt, out_rd, out_imm}); end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_spec_order();
    in_instr = {ADD, BEQ}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_spec !== 2'b10 || spec_count !== 3'd1) begin
      errors++; $display("FAIL br_slot0 got spec=%b sc=%0d need 10 1", out_spec, spec_count); end
    checks++; if (out_ctrl !== 12'b001000_000100 || out_func !== 6'b000_001) begin
      errors++; $display("FAIL br_slot0_ctrl got %b/%b need 001000000100/000001", out_ctrl, out_func); end
    checks++; if (out_rs !== {5'd1, 5'd1} || out_rd !== {5'd3, 5'd0} || out_imm !== {16'h1820, 16'h0004}) begin
      errors++; $display("FAIL br_slot0_fields got rs=%h rd=%h imm=%h", out_rs, out_rd, out_imm); end
    br_flush = 1'b1; tick(); br_flush = 1'b0;
    in_instr = {BEQ, ADD}; in_valid = 1'b1;
    tick();
    checks++; if (out_spec !== 2'b00 || spec_count !== 3'd1) begin
      errors++; $display("FAIL br_slot1 got spec=%b sc=%0d need 00 1", out_spec, spec_count); end
    in_instr = {LW, ADD};
    tick();
    in_valid = 1'b0;
    checks++; if (out_spec !== 2'b11 || spec_count !== 3'd1) begin
      errors++; $display("FAIL after_br got spec=%b sc=%0d need 11 1", out_spec, spec_count); end
  endtask

  task automatic test_depth_stall();
    br_flush = 1'b1; tick(); br_flush = 1'b0;
    in_instr = {BEQ, BEQ}; in_valid = 1'b1;
    tick(); tick();
    checks++; if (spec_count !== 3'd4) begin
      errors++; $display("FAIL depth_fill got %0d need 4", spec_count); end
    in_instr = {ADD, BEQ};
    #1;
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL depth_stall got in_ready=%b need 0", in_ready); end
    tick();
    checks++; if (spec_count !== 3'd4 || out_valid !== 1'b0) begin
      errors++; $display("FAIL depth_hold got sc=%0d ov=%b need 4 0", spec_count, out_valid); end
    br_resolve = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL depth_resolve_cycle got in_ready=%b need 0", in_ready); end
    tick();
    br_resolve = 1'b0;
    #1;
    checks++; if (spec_count !== 3'd3 || in_ready !== 1'b1) begin
      errors++; $display("FAIL depth_freed got sc=%0d rdy=%b need 3 1", spec_count, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (spec_count !== 3'd4 || out_valid !== 1'b1 || out_spec !== 2'b11) begin
      errors++; $display("FAIL depth_accept got sc=%0d ov=%b spec=%b need 4 1 11", spec_count, out_valid, out_spec); end
  endtask

  task automatic test_flush();
    br_flush = 1'b1; tick(); br_flush = 1'b0;
    in_valid = 1'b1; in_instr = {BEQ, BEQ}; tick();
    in_instr = {ADD, BEQ}; tick();
    checks++; if (spec_count !== 3'd3) begin
      errors++; $display("FAIL flush_setup got %0d need 3", spec_count); end
    in_instr = {ADD, ADD}; br_flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b need 0", in_ready); end
    tick();
    br_flush = 1'b0; in_valid = 1'b0;
    checks++; if (spec_count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear got sc=%0d ov=%b need 0 0", spec_count, out_valid); end
  endtask

  task automatic test_halt();
    in_instr = {ADD, HLT}; in_valid = 1'b1;
    tick();
    checks++; if (out_slot_valid !== 2'b01 || halted !== 1'b1 || out_ctrl[5:0] !== 6'b000001) begin
      errors++; $display("FAIL halt_accept got sv=%b h=%b c0=%b need 01 1 000001", out_slot_valid, halted, out_ctrl[5:0]); end
    in_instr = {ADD, ADD};
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_hold cycle %0d got rdy=%b h=%b need 0 1", i, in_ready, halted); end
      tick();
    end
    br_flush = 1'b1; tick(); br_flush = 1'b0; in_valid = 1'b0;
    checks++; if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_flush got %b need 0", halted); end
  endtask

  task automatic test_backpressure();
    logic [W*5*3+W*16-1:0] snap;
    out_ready = 1'b0;
    in_instr = {LW, ADD}; in_valid = 1'b1;
    tick();
    snap = {m_rs, m_rt, m_rd, m_imm};
    in_instr = {BEQ, BEQ};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready cycle %0d got %b need 0", i, in_ready); end
      tick();
      checks++; if ({out_rs, out_rt, out_rd, out_imm} !== snap || out_valid !== 1'b1 || out_ctrl !== 12'b010000_001000) begin
        errors++; $display("FAIL bp_hold cycle %0d got %h ov=%b need %h 1", i, {out_rs, out_rt, out_rd, out_imm}, out_valid, snap); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({out_valid, halted, spec_count, out_slot_valid, out_spec, out_ctrl, out_func} !== '0 ||
                  {out_rs, out_rt, out_rd, out_imm} !== '0) begin
      errors++; $display("FAIL bp_reset got ov=%b ctrl=%h rs=%h need 0", out_valid, out_ctrl, out_rs); end
    model_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    logic [W*32-1:0] b;
    for (int n = 0; n < 800; n++) begin
      for (int s = 0; s < W; s++) b[32*s +: 32] = mk(rand_kind());
      in_instr   = b;
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      br_resolve = ($urandom_range(0, 2) == 0);
      br_flush   = ($urandom_range(0, 11) == 0);
      #1;
      checks++; if (in_ready !== m_ready()) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b need %b", n, in_ready, m_ready()); end
      tick();
      checks++; if ({out_valid, halted, spec_count} !== {m_ov, m_halted, 3'(m_spec)}) begin
        errors++; $display("FAIL rand_state cycle %0d got ov=%b h=%b sc=%0d need %b %b %0d",
                           n, out_valid, halted, spec_count, m_ov, m_halted, m_spec); end
      checks++; if ({out_slot_valid, out_spec, out_ctrl, out_func} !== {m_sv, m_sp, m_ctrl, m_func}) begin
        errors++; $display("FAIL rand_dec cycle %0d got %h need %h", n,
                           {out_slot_valid, out_spec, out_ctrl, out_func}, {m_sv, m_sp, m_ctrl, m_func}); end
      checks++; if ({out_rs, out_rt, out_rd, out_imm} !== {m_rs, m_rt, m_rd, m_imm}) begin
        errors++; $display("FAIL rand_fields cycle %0d got %h need %h", n,
                           {out_rs, out_rt, out_rd, out_imm}, {m_rs, m_rt, m_rd, m_imm}); end
    end
    in_valid = 1'b0; br_resolve = 1'b0; br_flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    br_resolve = 1'b0; br_flush = 1'b0;
    model_reset();
    test_reset();
    test_spec_order();
    test_depth_stall();
    test_flush();
    test_halt();
    test_backpressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_wide.md
DECODE_WIDE -- requirements
Module: decode_wide

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning instructions per bundle (1..4).
REQ-002 SHALL have parameter SPEC_DEPTH, default 4, meaning max unresolved branches in flight (1..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning a bundle is present on in_instr.
REQ-006 SHALL have port in_ready, output, 1, meaning the bundle is accepted this cycle.
REQ-007 SHALL have port in_instr, input, WIDTH*32, meaning slot i is bits [32i+31:32i], oldest in slot 0.
REQ-008 SHALL have port out_valid, output, 1, meaning the decoded bundle register is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the downstream stage takes the bundle.
REQ-010 SHALL have port out_slot_valid, output, WIDTH, meaning slot i holds a live instruction.
REQ-011 SHALL have ports out_rs, out_rt and out_rd, output, WIDTH*5 each, meaning instr[25:21], instr[20:16] and instr[15:11].
REQ-012 SHALL have port out_imm, output, WIDTH*16, meaning instr[15:0].
REQ-013 SHALL have port out_ctrl, output, WIDTH*6, meaning {sw,lw,r,branch,jmp,hlt} from a per-slot ControlUnit instance.
REQ-014 SHALL have port out_func, output, WIDTH*3, meaning the ControlUnit func output.
REQ-015 SHALL have port out_spec, output, WIDTH, meaning slot i is speculative.
REQ-016 SHALL have port br_resolve, input, 1, meaning the oldest outstanding branch resolved correctly.
REQ-017 SHALL have port br_flush, input, 1, meaning mispredict; discard all speculative state.
REQ-018 SHALL have port spec_count, output, $clog2(SPEC_DEPTH+1), meaning the number of unresolved branches.
REQ-019 SHALL have port halted, output, 1, meaning a hlt has been accepted.

Function
REQ-020 SHALL decode combinationally from in_instr and register all out_* fields on accept (in_valid && in_ready), giving 1-cycle latency.
REQ-021 SHALL drive in_ready = (!out_valid || out_ready) && !halted && !br_flush && (spec_count + nb <= SPEC_DEPTH), where nb = branch slots in the incoming bundle.
REQ-022 SHALL clear out_valid on out_ready with no accept, and SHALL hold the out register stable while out_valid && !out_ready.
REQ-023 SHALL set out_spec[i] = (spec_count != 0) || (any slot j<i is a branch), evaluated at accept.
REQ-024 SHALL update spec_count next = spec_count + nb(accepted) - br_resolve; accept and resolve in the same cycle both apply.
REQ-025 SHALL ignore br_resolve when spec_count == 0 (no underflow).
REQ-026 SHALL, on br_flush, set spec_count=0, out_valid=0 and halted=0, and accept nothing; flush has priority over resolve and accept.
REQ-027 SHALL, when slot k of an accepted bundle has hlt=1, clear out_slot_valid for slots >k and set halted; in_ready stays 0 until rst or br_flush.
REQ-028 SHALL set out_slot_valid to all-ones for accepted bundles without hlt.
REQ-029 SHALL stall a bundle whose nb would exceed SPEC_DEPTH, whole bundle only; there is no partial accept.

Reset
REQ-030 SHALL on rst drive out_valid=0, out_slot_valid=0, out_spec=0, out_ctrl=0, out_func=0, out_rs/rt/rd/imm=0, spec_count=0 and halted=0, immediately and asynchronously.
REQ-031 SHALL discard an in-flight bundle when rst asserts mid-transfer; the first accept is allowed on the first clock edge after rst deasserts.

Configuration
REQ-032 SHALL, with DECODE_PERF_EN defined, add outputs perf_bundles (32-bit, counts accepts) and perf_spec_stall (32-bit, counts cycles with in_valid && !in_ready due to the REQ-021 depth term), both saturating at 2^32-1 and zeroed by rst.
REQ-033 SHALL, without DECODE_PERF_EN, omit these ports and counters entirely; all other behaviour is identical.

Verification
REQ-034 SHALL pass this scenario: WIDTH=2, spec_count=0, bundle {slot0 branch, slot1 add} -> next cycle out_spec=2'b10, spec_count=1.
REQ-035 SHALL pass this scenario: spec_count=0, bundle {slot0 add, slot1 branch} -> out_spec=2'b00, spec_count=1; a following non-branch bundle -> out_spec=2'b11.
REQ-036 SHALL pass this scenario: SPEC_DEPTH=2, spec_count=2, bundle with one branch -> in_ready=0; br_resolve for 1 cycle -> next cycle accepted, spec_count stays 2.
REQ-037 SHALL pass this scenario: spec_count=3, br_flush coincident with in_valid -> in_ready=0, next cycle spec_count=0 and out_valid=0.
REQ-038 SHALL pass this scenario: bundle {slot0 hlt, slot1 add} -> out_slot_valid=2'b01, halted=1, in_ready=0 for 10 cycles; br_flush -> halted=0.
REQ-039 SHALL pass this scenario: out_ready=0 for 3 cycles with out_valid=1 -> out fields unchanged and in_ready=0; rst mid-stall -> all outputs 0 within the same cycle.
